zeroheti_bus_arb: RTL and testbench
===================================

# zeroheti_bus_arb

Round-robin arbiter and address decoder that shares the zeroHETI system peripheral port between the core data port and the debug system-bus-access requester. It decodes each granted request against the shared address map (debug region, CLIC region, memory region), forwards it on a single OBI-style target port with a one-hot region select, and routes the response back to the owner. Unmapped accesses are answered locally with an error response. One transaction is outstanding at a time.

## Interface
- `NumReq`, default 2: number of requesters. Index 0 is the core LSU; index 1 is debug SBA.
- `AddrMap`, default `zeroheti_pkg::AddrMap`: region rules. `last` is exclusive.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  NumReq  per-requester request. Held, with stable payload, until granted.
- `addr_i`  in  NumReq×32  request address.
- `we_i`  in  NumReq  write enable.
- `be_i`  in  NumReq×4  byte enables.
- `wdata_i`  in  NumReq×32  write data.
- `gnt_o`  out  NumReq  grant, one-hot or zero.
- `rvalid_o`  out  NumReq  response valid, one-hot or zero.
- `rdata_o`  out  32  response data, shared by all requesters.
- `err_o`  out  1  response error, valid with `rvalid_o`.
- `t_req_o`  out  1  target request.
- `t_sel_o`  out  3  one-hot region select `{mem, clic, dbg}`.
- `t_addr_o`  out  32  target address.
- `t_we_o`  out  1  target write enable.
- `t_be_o`  out  4  target byte enables.
- `t_wdata_o`  out  32  target write data.
- `t_gnt_i`  in  1  target grant.
- `t_rvalid_i`  in  1  target response valid.
- `t_rdata_i`  in  32  target response data.
- `t_err_i`  in  1  target error, valid with `t_rvalid_i`.

## Operation
- States:
  - IDLE: no owner.
  - ADDR: winner locked, waiting for `t_gnt_i`.
  - RESP: waiting for `t_rvalid_i`.
  - ERR: local error response.
- Arbitration happens in IDLE only. Round-robin starts from pointer `rr_q`. The winner is the first asserted `req_i[k]` at or after `rr_q`, modulo `NumReq`. Once a request is issued, `rr_q` becomes winner+1, modulo `NumReq`.
- Decode: region hit when `base <= addr < last`.
  - dbg and clic are checked first, then mem.
  - Overlaps resolve in the priority order dbg > clic > mem.
  - No hit means unmapped.
- IDLE, mapped winner:
  - Drive `t_req_o`=1, `t_sel_o`, and the winner's payload combinationally.
  - If `t_gnt_i`=1: `gnt_o[w]`=1, go to RESP.
  - Otherwise latch the owner and region, go to ADDR.
- ADDR: keep driving the owner's payload; no re-arbitration. On `t_gnt_i`, `gnt_o[owner]`=1 and go to RESP.
- IDLE, unmapped winner: `gnt_o[w]`=1, `t_req_o`=0, go to ERR.
- ERR: `rvalid_o[owner]`=1, `err_o`=1, `rdata_o`=0, go to IDLE.
- RESP: `rvalid_o[owner]`, `rdata_o` and `err_o` follow `t_rvalid_i`, `t_rdata_i` and `t_err_i` combinationally. On `t_rvalid_i`, go to IDLE.
- Outside RESP and ERR: `rdata_o`=0 and `err_o`=0. `t_*` payload outputs are 0 when `t_req_o`=0.
- Responses arriving at `t_rvalid_i` outside RESP are ignored. The target protocol forbids them.

## Timing
- Reset values: state IDLE, `rr_q`=0, all outputs 0. Reset is asynchronous and may assert in any state. It aborts the transaction, and no response is delivered.
- Minimum latency with a zero-wait target: request and grant in cycle N, response no earlier than N+1.
- Error latency: grant in cycle N, `rvalid_o`+`err_o` in N+1.
- Throughput: one bubble after each response, because IDLE is re-entered the cycle after `rvalid_o`. Peak is one transaction per 2 cycles.
- `t_gnt_i` and `t_rvalid_i` in the same cycle are not allowed (one outstanding transaction). `t_rvalid_i` is sampled only from the cycle after the grant.
- Simultaneous requests: exactly one grant, by round-robin. A losing requester keeps `req_i` high and wins the next arbitration.

## Structure
- Add to `zeroheti_pkg`:
  - `MemAddr` rule: base `32'h0001_0000`, last `32'h0002_0000`.
  - A `mem` field in `addr_map_t` and `AddrMap`.
  - A `bus_state_e` enum: IDLE, ADDR, RESP, ERR.
  - A `region_e` enum: DBG, CLIC, MEM, NONE.
- One sub-module, `zeroheti_addr_decode`: purely combinational, takes a 32-bit address and the map, returns `region_e`. It is reused later by the core's PMA check.

## Test plan
- Core reads `0x9004`, target grants at once and responds 1 cycle later with `0xDEADBEEF` → `t_sel_o`=3'b010, `gnt_o`=2'b01 in cycle 0, `rvalid_o`=2'b01 and `rdata_o`=`0xDEADBEEF` in cycle 1, `err_o`=0.
- Both requesters assert from reset, both targeting `0x0100`, repeated 4 times → grant order 0,1,0,1; `t_sel_o`=3'b001 each time.
- Debug writes `0x0000_8000` (unmapped) → `gnt_o`=2'b10 with `t_req_o`=0, then `rvalid_o`=2'b10, `err_o`=1, `rdata_o`=0 on the next cycle.
- Core targets `0x1_0000`, `t_gnt_i` held low for 3 cycles while debug also requests → payload stays on core's address, `t_sel_o`=3'b100, debug is granted only after core's response.
- `rst_ni` pulsed low while in RESP → all outputs 0 immediately. After release, a late `t_rvalid_i` produces no `rvalid_o`, and the next request is arbitrated from `rr_q`=0.

Source files
------------

// File: rtl/zeroheti_pkg.sv
// Shared zeroHETI definitions: system address map, bus arbiter states and region codes.
package zeroheti_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } addr_rule_t;

  typedef struct packed {
    addr_rule_t dbg;
    addr_rule_t clic;
    addr_rule_t mem;
  } addr_map_t;

  localparam addr_rule_t DbgAddr  = '{base: 32'h0000_0000, last: 32'h0000_1000};
  localparam addr_rule_t ClicAddr = '{base: 32'h0000_9000, last: 32'h0000_A000};
  localparam addr_rule_t MemAddr  = '{base: 32'h0001_0000, last: 32'h0002_0000};

  localparam addr_map_t AddrMap = '{dbg: DbgAddr, clic: ClicAddr, mem: MemAddr};

  typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} bus_state_e;
  typedef enum logic [1:0] {DBG, CLIC, MEM, NONE} region_e;

  // One-hot target select, ordered {mem, clic, dbg}.
  function automatic logic [2:0] region_sel(region_e r);
    case (r)
      DBG:     region_sel = 3'b001;
      CLIC:    region_sel = 3'b010;
      MEM:     region_sel = 3'b100;
      default: region_sel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/zeroheti_addr_decode.sv
// Combinational address-to-region decoder; shared with the core's PMA check.
module zeroheti_addr_decode
  import zeroheti_pkg::*;
(
  input  logic [31:0] addr,
  input  addr_map_t   map,
  output region_e     region
);

  function automatic logic hit(logic [31:0] a, addr_rule_t r);
    hit = (a >= r.base) && (a < r.last);
  endfunction

  // Overlapping rules resolve dbg > clic > mem.
  always_comb begin
    region = NONE;
    if (hit(addr, map.dbg))       region = DBG;
    else if (hit(addr, map.clic)) region = CLIC;
    else if (hit(addr, map.mem))  region = MEM;
  end

endmodule

// File: rtl/zeroheti_bus_arb.sv
// Round-robin arbiter + decoder sharing the peripheral port between core LSU and debug SBA.
module zeroheti_bus_arb
  import zeroheti_pkg::*;
#(
  parameter int        NumReq  = 2,
  parameter addr_map_t AddrMap = zeroheti_pkg::AddrMap
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0][31:0]  addr_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq-1:0][3:0]   be_i,
  input  logic [NumReq-1:0][31:0]  wdata_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic                     t_req_o,
  output logic [2:0]               t_sel_o,
  output logic [31:0]              t_addr_o,
  output logic                     t_we_o,
  output logic [3:0]               t_be_o,
  output logic [31:0]              t_wdata_o,
  input  logic                     t_gnt_i,
  input  logic                     t_rvalid_i,
  input  logic [31:0]              t_rdata_i,
  input  logic                     t_err_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  bus_state_e      state_q;
  region_e         region_q, win_region;
  logic [IdxW-1:0] owner_q, rr_q, winner, cand, rr_next;
  logic            found;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((int'(rr_q) + i) % NumReq);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign rr_next = (int'(winner) == NumReq - 1) ? '0 : IdxW'(winner + 1'b1);

  zeroheti_addr_decode u_decode (
    .addr   (addr_i[winner]),
    .map    (AddrMap),
    .region (win_region)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      region_q <= NONE;
      owner_q  <= '0;
      rr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          owner_q  <= winner;
          region_q <= win_region;
          rr_q     <= rr_next;
          if (win_region == NONE) state_q <= ERR;
          else if (t_gnt_i)       state_q <= RESP;
          else                    state_q <= ADDR;
        end
        ADDR:    if (t_gnt_i)    state_q <= RESP;
        RESP:    if (t_rvalid_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Payload is driven only while t_req_o is high; everything else stays at zero.
  always_comb begin
    gnt_o     = '0;
    rvalid_o  = '0;
    rdata_o   = '0;
    err_o     = 1'b0;
    t_req_o   = 1'b0;
    t_sel_o   = '0;
    t_addr_o  = '0;
    t_we_o    = 1'b0;
    t_be_o    = '0;
    t_wdata_o = '0;
    case (state_q)
      IDLE: if (found) begin
        if (win_region == NONE) begin
          gnt_o[winner] = 1'b1;
        end else begin
          t_req_o   = 1'b1;
          t_sel_o   = region_sel(win_region);
          t_addr_o  = addr_i[winner];
          t_we_o    = we_i[winner];
          t_be_o    = be_i[winner];
          t_wdata_o = wdata_i[winner];
          gnt_o[winner] = t_gnt_i;
        end
      end
      ADDR: begin
        t_req_o   = 1'b1;
        t_sel_o   = region_sel(region_q);
        t_addr_o  = addr_i[owner_q];
        t_we_o    = we_i[owner_q];
        t_be_o    = be_i[owner_q];
        t_wdata_o = wdata_i[owner_q];
        gnt_o[owner_q] = t_gnt_i;
      end
      RESP: begin
        rvalid_o[owner_q] = t_rvalid_i;
        rdata_o           = t_rdata_i;
        err_o             = t_err_i;
      end
      ERR: begin
        rvalid_o[owner_q] = 1'b1;
        err_o             = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zeroheti_bus_arb.sv
// Directed bench for zeroheti_bus_arb: decode, round-robin, error path, stalls, reset abort.
module tb_zeroheti_bus_arb;

  logic             clk_i, rst_ni;
  logic [1:0]       req_i, we_i, gnt_o, rvalid_o;
  logic [1:0][31:0] addr_i, wdata_i;
  logic [1:0][3:0]  be_i;
  logic [31:0]      rdata_o, t_addr_o, t_wdata_o, t_rdata_i;
  logic             err_o, t_req_o, t_we_o, t_gnt_i, t_rvalid_i, t_err_i;
  logic [2:0]       t_sel_o;
  logic [3:0]       t_be_o;

  int n_vec = 0;
  int n_err = 0;

  zeroheti_bus_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .t_req_o(t_req_o), .t_sel_o(t_sel_o),
    .t_addr_o(t_addr_o), .t_we_o(t_we_o), .t_be_o(t_be_o), .t_wdata_o(t_wdata_o),
    .t_gnt_i(t_gnt_i), .t_rvalid_i(t_rvalid_i), .t_rdata_i(t_rdata_i), .t_err_i(t_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [1:0] eg;
    rst_ni = 1'b0; req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
    t_gnt_i = 1'b0; t_rvalid_i = 1'b0; t_rdata_i = '0; t_err_i = 1'b0;
    #3;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_treq", 32'(t_req_o), 32'h0);
    chk("rst_tsel", 32'(t_sel_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    tick(); rst_ni = 1'b1;

    // core read of the CLIC, zero-wait target
    tick(); req_i = 2'b01; addr_i[0] = 32'h9004; t_gnt_i = 1'b1;
    #4;
    chk("clic_tsel", 32'(t_sel_o), 32'h2);
    chk("clic_gnt", 32'(gnt_o), 32'h1);
    chk("clic_treq", 32'(t_req_o), 32'h1);
    chk("clic_taddr", t_addr_o, 32'h9004);
    tick(); req_i = 2'b00; t_gnt_i = 1'b0; t_rvalid_i = 1'b1; t_rdata_i = 32'hDEADBEEF;
    #4;
    chk("clic_rvalid", 32'(rvalid_o), 32'h1);
    chk("clic_rdata", rdata_o, 32'hDEADBEEF);
    chk("clic_err", 32'(err_o), 32'h0);
    chk("clic_gnt_resp", 32'(gnt_o), 32'h0);
    tick(); t_rvalid_i = 1'b0; t_rdata_i = '0;

    // fresh reset so arbitration starts at requester 0
    rst_ni = 1'b0; #1; rst_ni = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      req_i = 2'b11; addr_i[0] = 32'h100; addr_i[1] = 32'h100; we_i = 2'b10;
      be_i[0] = 4'h5; be_i[1] = 4'hA; wdata_i[0] = 32'h1111_0000; wdata_i[1] = 32'hCAFE_0001;
      t_gnt_i = 1'b1; t_rvalid_i = 1'b0;
      eg = (n % 2 == 0) ? 2'b01 : 2'b10;
      #4;
      chk("rr_gnt", 32'(gnt_o), 32'(eg));
      chk("rr_tsel", 32'(t_sel_o), 32'h1);
      chk("rr_twe", 32'(t_we_o), (n % 2 == 0) ? 32'h0 : 32'h1);
      chk("rr_tbe", 32'(t_be_o), (n % 2 == 0) ? 32'h5 : 32'hA);
      chk("rr_twdata", t_wdata_o, (n % 2 == 0) ? 32'h1111_0000 : 32'hCAFE_0001);
      tick(); t_gnt_i = 1'b0; t_rvalid_i = 1'b1; t_rdata_i = 32'(n);
      #4;
      chk("rr_rvalid", 32'(rvalid_o), 32'(eg));
      chk("rr_rdata", rdata_o, 32'(n));
    end
    tick(); req_i = 2'b00; t_rvalid_i = 1'b0; we_i = '0;

    // debug write to an unmapped hole
    tick(); req_i = 2'b10; addr_i[1] = 32'h0000_8000; we_i = 2'b10; t_rdata_i = 32'h55;
    #4;
    chk("unm_gnt", 32'(gnt_o), 32'h2);
    chk("unm_treq", 32'(t_req_o), 32'h0);
    chk("unm_tsel", 32'(t_sel_o), 32'h0);
    chk("unm_taddr", t_addr_o, 32'h0);
    chk("unm_twe", 32'(t_we_o), 32'h0);
    tick(); req_i = 2'b00; we_i = '0;
    #4;
    chk("unm_rvalid", 32'(rvalid_o), 32'h2);
    chk("unm_err", 32'(err_o), 32'h1);
    chk("unm_rdata", rdata_o, 32'h0);

    // core to memory with a stalling target while debug waits
    tick(); req_i = 2'b11; addr_i[0] = 32'h0001_0000; addr_i[1] = 32'h100; t_gnt_i = 1'b0;
    #4;
    chk("stall_tsel", 32'(t_sel_o), 32'h4);
    chk("stall_taddr0", t_addr_o, 32'h0001_0000);
    chk("stall_gnt0", 32'(gnt_o), 32'h0);
    for (int c = 1; c < 3; c++) begin
      tick(); #4;
      chk("stall_taddr", t_addr_o, 32'h0001_0000);
      chk("stall_tsel_hold", 32'(t_sel_o), 32'h4);
      chk("stall_gnt", 32'(gnt_o), 32'h0);
    end
    tick(); t_gnt_i = 1'b1;
    #4;
    chk("stall_gnt_core", 32'(gnt_o), 32'h1);
    chk("stall_taddr_gnt", t_addr_o, 32'h0001_0000);
    tick(); req_i = 2'b10; t_gnt_i = 1'b0; t_rvalid_i = 1'b1; t_rdata_i = 32'h1234;
    #4;
    chk("stall_rvalid_core", 32'(rvalid_o), 32'h1);
    chk("stall_no_dbg_gnt", 32'(gnt_o), 32'h0);
    tick(); t_rvalid_i = 1'b0; t_gnt_i = 1'b1;
    #4;
    chk("stall_gnt_dbg", 32'(gnt_o), 32'h2);
    chk("stall_tsel_dbg", 32'(t_sel_o), 32'h1);
    chk("stall_taddr_dbg", t_addr_o, 32'h100);
    tick(); req_i = 2'b00; t_gnt_i = 1'b0; t_rvalid_i = 1'b1;
    #4;
    chk("stall_rvalid_dbg", 32'(rvalid_o), 32'h2);
    tick(); t_rvalid_i = 1'b0;

    // reset during RESP, after core win moved the pointer to 1
    tick(); req_i = 2'b01; addr_i[0] = 32'h9004; t_gnt_i = 1'b1;
    #4;
    chk("ab_gnt", 32'(gnt_o), 32'h1);
    tick(); req_i = 2'b00; t_gnt_i = 1'b0; t_rdata_i = 32'hAAAA_5555;
    #4;
    rst_ni = 1'b0; t_rvalid_i = 1'b1;
    #1;
    chk("ab_rvalid", 32'(rvalid_o), 32'h0);
    chk("ab_rdata", rdata_o, 32'h0);
    chk("ab_err", 32'(err_o), 32'h0);
    chk("ab_treq", 32'(t_req_o), 32'h0);
    chk("ab_gnt_rst", 32'(gnt_o), 32'h0);
    tick(); tick(); rst_ni = 1'b1;
    #4;
    chk("ab_late_rvalid", 32'(rvalid_o), 32'h0);
    chk("ab_late_rdata", rdata_o, 32'h0);
    tick(); t_rvalid_i = 1'b0; req_i = 2'b11; addr_i[0] = 32'h100; addr_i[1] = 32'h100; t_gnt_i = 1'b1;
    #4;
    chk("ab_rr_gnt", 32'(gnt_o), 32'h1);
    tick(); req_i = 2'b00; t_gnt_i = 1'b0; t_rvalid_i = 1'b1;
    #4;
    chk("ab_rr_rvalid", 32'(rvalid_o), 32'h1);
    tick(); t_rvalid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
